// File: rtl/act_bram_engine.sv
// act_bram_engine: in-place activation pass over the conv feature-map BRAM.
// Every element is read through port A, run through the selected activation
// and written back through port B at the same address, one element per clock.
// The read side tolerates a BRAM read latency of RD_LATENCY cycles (1..4).
// Optional feature: define ACT_STATS_EN to add the neg_count output, which
// reports how many elements of the last pass were negative.
module act_bram_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_H      = 28,
    parameter int IMG_W      = 28,
    parameter int RD_LATENCY = 1,
    parameter int LEAK_SHIFT = 3,
    localparam int N         = CHANNELS * IMG_H * IMG_W,
    localparam int ADDR_W    = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic signed [DATA_WIDTH-1:0] clamp_max,
    output logic [ADDR_W-1:0]            conv_r_addr,
    output logic                         conv_r_en,
    input  logic signed [DATA_WIDTH-1:0] conv_r_q,
    output logic [ADDR_W-1:0]            conv_w_addr,
    output logic                         conv_w_en,
    output logic                         conv_w_we,
    output logic signed [DATA_WIDTH-1:0] conv_w_d,
`ifdef ACT_STATS_EN
    output logic [ADDR_W:0]              neg_count,
`endif
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t                       state;
    logic [1:0]                   mode_q;
    logic signed [DATA_WIDTH-1:0] clamp_q;

    // Read tracking: one valid bit and address per outstanding BRAM read.
    logic [RD_LATENCY-1:0]        rd_vld;
    logic [ADDR_W-1:0]            rd_adr [RD_LATENCY];

    // The oldest tracking slot lines up with the cycle conv_r_q carries its data.
    logic                         rd_ret;
    logic [ADDR_W-1:0]            rd_ret_adr;

    assign rd_ret     = rd_vld[RD_LATENCY-1];
    assign rd_ret_adr = rd_adr[RD_LATENCY-1];

    // Activation of one element. A negative clamp bound forces every clamped
    // output to zero, so it is tested before the upper-bound comparison.
    function automatic logic signed [DATA_WIDTH-1:0] activate(
        input logic signed [DATA_WIDTH-1:0] v,
        input logic [1:0]                   m,
        input logic signed [DATA_WIDTH-1:0] cmax
    );
        logic signed [DATA_WIDTH-1:0] r;
        r = v;
        case (m)
            2'd0: r = v;
            2'd1: r = v[DATA_WIDTH-1] ? '0 : v;
            2'd2: r = v[DATA_WIDTH-1] ? (v >>> LEAK_SHIFT) : v;
            default: begin
                if (v[DATA_WIDTH-1] || cmax[DATA_WIDTH-1]) begin
                    r = '0;
                end else if (v > cmax) begin
                    r = cmax;
                end else begin
                    r = v;
                end
            end
        endcase
        return r;
    endfunction

    // Control FSM: accepts start, walks the read address, waits for the last write, pulses done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mode_q      <= '0;
            clamp_q     <= '0;
            conv_r_en   <= 1'b0;
            conv_r_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= ISSUE;
                        mode_q      <= mode;
                        clamp_q     <= clamp_max;
                        conv_r_en   <= 1'b1;
                        conv_r_addr <= '0;
                        busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (conv_r_addr == LAST_ADDR) begin
                        state       <= DRAIN;
                        conv_r_en   <= 1'b0;
                        conv_r_addr <= '0;
                    end else begin
                        conv_r_addr <= conv_r_addr + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (conv_w_en && conv_w_addr == LAST_ADDR) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    conv_r_en <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Shift each issued read down the tracking line until its data returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                rd_adr[k] <= '0;
            end
        end else begin
            rd_vld[0] <= conv_r_en;
            rd_adr[0] <= conv_r_addr;
            for (int k = 1; k < RD_LATENCY; k++) begin
                rd_vld[k] <= rd_vld[k-1];
                rd_adr[k] <= rd_adr[k-1];
            end
        end
    end

    // Capture returning data, apply the latched activation and drive the write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_w_en   <= 1'b0;
            conv_w_we   <= 1'b0;
            conv_w_addr <= '0;
            conv_w_d    <= '0;
        end else begin
            conv_w_en <= rd_ret;
            conv_w_we <= rd_ret;
            if (rd_ret) begin
                conv_w_addr <= rd_ret_adr;
                conv_w_d    <= activate(conv_r_q, mode_q, clamp_q);
            end
        end
    end

`ifdef ACT_STATS_EN
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    // Count negative inputs of the current pass, independent of the activation mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_count <= '0;
        end else if (state == IDLE && start) begin
            neg_count <= '0;
        end else if (rd_ret && conv_r_q[DATA_WIDTH-1]) begin
            neg_count <= neg_count + CNT_ONE;
        end
    end
`endif

endmodule
